// File: rtl/rob.sv
// Reorder buffer: in-order retire of up to 2*SIZE-1 entries with a per-register rename map.
// Optional ROB_BYPASS_EN: a completion at the head retires or flushes on the same edge it arrives.
module rob #(
    parameter  int WIDTH = 32,
    parameter  int SIZE  = 8,
    localparam int IW    = $clog2(SIZE) + 1,
    localparam int DEPTH = 2 * SIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc,
    input  logic [4:0]       alloc_rd,
    input  logic [4:0]       rl,
    input  logic [4:0]       rr,
    output logic             full,
    output logic [IW-1:0]    rob_next,
    output logic [1:0]       rob_wait,
    output logic [IW-1:0]    rob_rl,
    output logic [IW-1:0]    rob_rr,
    input  logic             ntf,
    input  logic [2:0]       exc,
    input  logic [WIDTH-1:0] val,
    input  logic [IW-1:0]    at,
    output logic [4:0]       rwrite,
    output logic [IW-1:0]    rbus,
    output logic [WIDTH-1:0] result,
    output logic             flush,
    output logic [2:0]       flush_exc,
    output logic [IW-1:0]    flush_at
);
    localparam logic [4:0] R_ZERO   = 5'd0;
    localparam logic [4:0] R_IMM    = 5'h1F;
    localparam logic [2:0] EXC_NONE = 3'd0;

    // Index 0 is reserved as "no producer", so the ring runs 1..DEPTH-1.
    function automatic logic [IW-1:0] f_next(input logic [IW-1:0] i);
        return (i == IW'(DEPTH - 1)) ? IW'(1) : i + IW'(1);
    endfunction

    logic [DEPTH-1:0] r_busy, r_done;
    logic [4:0]       r_rd  [DEPTH];
    logic [WIDTH-1:0] r_val [DEPTH];
    logic [2:0]       r_exc [DEPTH];
    logic [IW-1:0]    r_map [32];
    logic [31:0]      r_pend;
    logic [IW-1:0]    r_head, r_tail, r_count;

    logic [4:0]       r_rwrite;
    logic [IW-1:0]    r_rbus, r_flush_at;
    logic [WIDTH-1:0] r_result;
    logic             r_flush;
    logic [2:0]       r_flush_exc;

    logic             w_full, w_byp, w_hready, w_retire, w_flush, w_alloc, w_ntf, w_clr;
    logic [2:0]       w_hexc;
    logic [WIDTH-1:0] w_hval;
    logic [4:0]       w_hrd;

`ifdef ROB_BYPASS_EN
    assign w_byp = ntf && (at == r_head) && r_busy[r_head] && !r_done[r_head];
`else
    assign w_byp = 1'b0;
`endif

    assign w_full   = (r_count == IW'(DEPTH - 1));
    assign w_hexc   = w_byp ? exc : r_exc[r_head];
    assign w_hval   = w_byp ? val : r_val[r_head];
    assign w_hrd    = r_rd[r_head];
    assign w_hready = r_busy[r_head] && (r_done[r_head] || w_byp);
    assign w_retire = w_hready && (w_hexc == EXC_NONE);
    assign w_flush  = w_hready && (w_hexc != EXC_NONE);
    assign w_alloc  = alloc && !w_full && !w_flush;
    assign w_ntf    = ntf && r_busy[at] && !w_flush;
    // A younger producer of the same register keeps it pending.
    assign w_clr    = w_retire && (w_hrd != R_ZERO) && (r_map[w_hrd] == r_head);

    assign full        = w_full;
    assign rob_next    = r_tail;
    assign rob_rl      = r_map[rl];
    assign rob_rr      = r_map[rr];
    assign rob_wait[1] = r_pend[rl] && (rl != R_ZERO) && !(w_retire && (r_map[rl] == r_head));
    assign rob_wait[0] = r_pend[rr] && (rr != R_ZERO) && (rr != R_IMM)
                         && !(w_retire && (r_map[rr] == r_head));

    assign rwrite    = r_rwrite;
    assign rbus      = r_rbus;
    assign result    = r_result;
    assign flush     = r_flush;
    assign flush_exc = r_flush_exc;
    assign flush_at  = r_flush_at;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy      <= '0;
            r_done      <= '0;
            r_pend      <= '0;
            r_head      <= IW'(1);
            r_tail      <= IW'(1);
            r_count     <= '0;
            r_rwrite    <= R_ZERO;
            r_rbus      <= '0;
            r_result    <= '0;
            r_flush     <= 1'b0;
            r_flush_exc <= EXC_NONE;
            r_flush_at  <= '0;
        end else if (w_flush) begin
            r_busy      <= '0;
            r_done      <= '0;
            r_pend      <= '0;
            r_head      <= IW'(1);
            r_tail      <= IW'(1);
            r_count     <= '0;
            r_rwrite    <= R_ZERO;
            r_flush     <= 1'b1;
            r_flush_exc <= w_hexc;
            r_flush_at  <= r_head;
        end else begin
            r_flush  <= 1'b0;
            r_rwrite <= R_ZERO;
            if (w_ntf)
                r_done[at] <= 1'b1;
            // Retire clears come after the ntf set so a bypassed head ends up free.
            if (w_retire) begin
                r_busy[r_head] <= 1'b0;
                r_done[r_head] <= 1'b0;
                r_rwrite       <= w_hrd;
                r_rbus         <= r_head;
                r_result       <= w_hval;
                r_head         <= f_next(r_head);
                if (w_clr)
                    r_pend[w_hrd] <= 1'b0;
            end
            if (w_alloc) begin
                r_busy[r_tail] <= 1'b1;
                r_done[r_tail] <= 1'b0;
                r_tail         <= f_next(r_tail);
                if (alloc_rd != R_ZERO)
                    r_pend[alloc_rd] <= 1'b1;
            end
            case ({w_alloc, w_retire})
                2'b10:   r_count <= r_count + IW'(1);
                2'b01:   r_count <= r_count - IW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_rd[r_tail] <= alloc_rd;
            if (alloc_rd != R_ZERO)
                r_map[alloc_rd] <= r_tail;
        end
        if (w_ntf) begin
            r_val[at] <= val;
            r_exc[at] <= exc;
        end
    end
endmodule

// File: tb/tb_rob.sv
// Bench for rob: scoreboard of expected retirements/flushes plus a table of lookup vectors.
module tb_rob;
    localparam int WIDTH = 32;
    localparam int IW    = 4;
    localparam logic [2:0] EXC_BPRED = 3'd1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             alloc = 1'b0;
    logic [4:0]       alloc_rd = '0, rl = '0, rr = '0;
    logic             full;
    logic [IW-1:0]    rob_next, rob_rl, rob_rr;
    logic [1:0]       rob_wait;
    logic             ntf = 1'b0;
    logic [2:0]       exc = '0;
    logic [WIDTH-1:0] val = '0;
    logic [IW-1:0]    at = '0;
    logic [4:0]       rwrite;
    logic [IW-1:0]    rbus, flush_at;
    logic [WIDTH-1:0] result;
    logic             flush;
    logic [2:0]       flush_exc;

    always #5 clk = ~clk;

    rob #(.WIDTH(WIDTH), .SIZE(8)) dut (
        .clk(clk), .rst(rst), .alloc(alloc), .alloc_rd(alloc_rd), .rl(rl), .rr(rr),
        .full(full), .rob_next(rob_next), .rob_wait(rob_wait), .rob_rl(rob_rl), .rob_rr(rob_rr),
        .ntf(ntf), .exc(exc), .val(val), .at(at),
        .rwrite(rwrite), .rbus(rbus), .result(result),
        .flush(flush), .flush_exc(flush_exc), .flush_at(flush_at)
    );

    typedef struct { logic [4:0] rd; logic [IW-1:0] idx; logic [WIDTH-1:0] v; } ret_t;
    typedef struct { logic [2:0] e; logic [IW-1:0] a; } fl_t;
    ret_t exp_q[$];
    fl_t  fl_q[$];
    int   errs = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        alloc = 1'b0;
        ntf   = 1'b0;
        exc   = '0;
    endtask

    task automatic push_ret(input logic [4:0] rd, input logic [IW-1:0] idx, input logic [WIDTH-1:0] v);
        ret_t r;
        r.rd = rd; r.idx = idx; r.v = v;
        exp_q.push_back(r);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (exp_q.size() != 0 || fl_q.size() != 0); i++)
            tick();
        chk("drain outstanding", 64'(exp_q.size() + fl_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Registered-output monitor: every retirement and flush must match the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (rwrite != 5'd0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected retire", 64'(rwrite), 64'd0);
                end else begin
                    ret_t e;
                    e = exp_q.pop_front();
                    chk("retire rd", 64'(rwrite), 64'(e.rd));
                    chk("retire rbus", 64'(rbus), 64'(e.idx));
                    chk("retire result", 64'(result), 64'(e.v));
                end
            end
            if (flush) begin
                if (fl_q.size() == 0) begin
                    chk("unexpected flush", 64'(flush), 64'd0);
                end else begin
                    fl_t f;
                    f = fl_q.pop_front();
                    chk("flush_exc", 64'(flush_exc), 64'(f.e));
                    chk("flush_at", 64'(flush_at), 64'(f.a));
                    chk("flush rwrite", 64'(rwrite), 64'd0);
                end
            end
        end
    end

    typedef struct {
        logic a; logic [4:0] ard, srl, srr; logic n; logic [IW-1:0] nat; logic [WIDTH-1:0] nv;
        logic ef; logic [IW-1:0] enext; logic [1:0] ewait; logic cm; logic [IW-1:0] erl, err;
    } vec_t;
    vec_t vt[9];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        fl_t fl;
        vt[0] = '{1'b1, 5'd31, 5'd31, 5'd31, 1'b0, 4'd0, 32'h0,  1'b0, 4'd1, 2'b00, 1'b0, 4'd0, 4'd0};
        vt[1] = '{1'b1, 5'd7,  5'd31, 5'd31, 1'b0, 4'd0, 32'h0,  1'b0, 4'd2, 2'b10, 1'b1, 4'd1, 4'd1};
        vt[2] = '{1'b0, 5'd0,  5'd7,  5'd7,  1'b0, 4'd0, 32'h0,  1'b0, 4'd3, 2'b11, 1'b1, 4'd2, 4'd2};
        vt[3] = '{1'b0, 5'd0,  5'd31, 5'd7,  1'b1, 4'd2, 32'hBB, 1'b0, 4'd3, 2'b11, 1'b1, 4'd1, 4'd2};
        vt[4] = '{1'b0, 5'd0,  5'd7,  5'd31, 1'b1, 4'd1, 32'hAA, 1'b0, 4'd3, 2'b10, 1'b1, 4'd2, 4'd1};
        vt[5] = '{1'b0, 5'd0,  5'd31, 5'd0,  1'b0, 4'd0, 32'h0,  1'b0, 4'd3, 2'b00, 1'b0, 4'd0, 4'd0};
        vt[6] = '{1'b0, 5'd0,  5'd7,  5'd0,  1'b0, 4'd0, 32'h0,  1'b0, 4'd3, 2'b00, 1'b0, 4'd0, 4'd0};
        vt[7] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 4'd0, 32'h0,  1'b0, 4'd3, 2'b00, 1'b0, 4'd0, 4'd0};
        vt[8] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 4'd0, 32'h0,  1'b0, 4'd4, 2'b00, 1'b0, 4'd0, 4'd0};

        // Asynchronous reset values
        #2 rst = 1'b0;
        #1;
        chk("reset rwrite", 64'(rwrite), 64'd0);
        chk("reset rbus", 64'(rbus), 64'd0);
        chk("reset result", 64'(result), 64'd0);
        chk("reset flush", 64'(flush), 64'd0);
        chk("reset flush_exc", 64'(flush_exc), 64'd0);
        chk("reset flush_at", 64'(flush_at), 64'd0);
        chk("reset full", 64'(full), 64'd0);
        chk("reset rob_next", 64'(rob_next), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // First alloc and lookup
        alloc = 1'b1; alloc_rd = 5'd3; rl = 5'd3; rr = 5'd0;
        #1;
        chk("pre-alloc rob_next", 64'(rob_next), 64'd1);
        chk("pre-alloc rob_wait", 64'(rob_wait), 64'd0);
        tick();
        chk("post-alloc rob_next", 64'(rob_next), 64'd2);
        chk("lookup rob_wait", 64'(rob_wait), 64'b10);
        chk("lookup rob_rl", 64'(rob_rl), 64'd1);

        // Out-of-order completion, in-order retire
        alloc = 1'b1; alloc_rd = 5'd4;
        tick();
        ntf = 1'b1; at = 4'd2; val = 32'h22;
        tick();
        ntf = 1'b1; at = 4'd1; val = 32'h11;
        push_ret(5'd3, 4'd1, 32'h11);
        push_ret(5'd4, 4'd2, 32'h22);
        tick();
        drain();
        rl = 5'd3; rr = 5'd4;
        #1;
        chk("post-retire rob_wait", 64'(rob_wait), 64'd0);
        chk("post-retire rob_next", 64'(rob_next), 64'd3);

        // Table-driven lookup/alloc vectors from a clean state
        do_reset();
        push_ret(5'd31, 4'd1, 32'hAA);
        push_ret(5'd7, 4'd2, 32'hBB);
        for (int i = 0; i < 9; i++) begin
            alloc = vt[i].a; alloc_rd = vt[i].ard; rl = vt[i].srl; rr = vt[i].srr;
            ntf = vt[i].n; at = vt[i].nat; val = vt[i].nv; exc = 3'd0;
            #1;
            chk($sformatf("vec%0d full", i), 64'(full), 64'(vt[i].ef));
            chk($sformatf("vec%0d rob_next", i), 64'(rob_next), 64'(vt[i].enext));
            chk($sformatf("vec%0d rob_wait", i), 64'(rob_wait), 64'(vt[i].ewait));
            if (vt[i].cm) begin
                chk($sformatf("vec%0d rob_rl", i), 64'(rob_rl), 64'(vt[i].erl));
                chk($sformatf("vec%0d rob_rr", i), 64'(rob_rr), 64'(vt[i].err));
            end
            tick();
        end
        drain();

        // Fill to full, overflow ignored, wrap after one retire
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            alloc = 1'b1; alloc_rd = 5'(i);
            tick();
        end
        chk("full after 15", 64'(full), 64'd1);
        chk("full rob_next", 64'(rob_next), 64'd1);
        alloc = 1'b1; alloc_rd = 5'd20;
        tick();
        rl = 5'd20; rr = 5'd15;
        #1;
        chk("overflow full", 64'(full), 64'd1);
        chk("overflow rob_next", 64'(rob_next), 64'd1);
        chk("overflow rob_wait", 64'(rob_wait), 64'b01);
        chk("overflow rob_rr", 64'(rob_rr), 64'd15);
        ntf = 1'b1; at = 4'd1; val = 32'h100;
        push_ret(5'd1, 4'd1, 32'h100);
        tick();
        drain();
        chk("after retire full", 64'(full), 64'd0);
        chk("after retire rob_next", 64'(rob_next), 64'd1);
        alloc = 1'b1; alloc_rd = 5'd9; rl = 5'd9;
        tick();
        chk("wrap rob_next", 64'(rob_next), 64'd2);
        chk("wrap full", 64'(full), 64'd1);
        chk("wrap rob_rl", 64'(rob_rl), 64'd1);

        // Reset in the middle of operation
        #2 rst = 1'b0;
        #1;
        chk("midreset full", 64'(full), 64'd0);
        chk("midreset rob_next", 64'(rob_next), 64'd1);
        chk("midreset rob_wait", 64'(rob_wait), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        alloc = 1'b1; alloc_rd = 5'd12; rl = 5'd12;
        tick();
        chk("post-reset rob_next", 64'(rob_next), 64'd2);
        chk("post-reset rob_rl", 64'(rob_rl), 64'd1);

        // Exception at head flushes everything; alloc/ntf in the decision cycle dropped
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            alloc = 1'b1; alloc_rd = 5'(i);
            tick();
        end
        ntf = 1'b1; at = 4'd1; exc = EXC_BPRED; val = 32'h99;
        fl.e = EXC_BPRED; fl.a = 4'd1;
        fl_q.push_back(fl);
`ifdef ROB_BYPASS_EN
        alloc = 1'b1; alloc_rd = 5'd6;
        tick();
`else
        tick();
        alloc = 1'b1; alloc_rd = 5'd6;
        ntf = 1'b1; at = 4'd2; val = 32'h55; exc = 3'd0;
        tick();
`endif
        drain();
        chk("flush one cycle", 64'(flush), 64'd0);
        chk("flush full", 64'(full), 64'd0);
        chk("flush rob_next", 64'(rob_next), 64'd1);
        rl = 5'd3; rr = 5'd6;
        #1;
        chk("flush pending cleared", 64'(rob_wait), 64'd0);
        alloc = 1'b1; alloc_rd = 5'd2;
        tick();
        chk("flush realloc rob_next", 64'(rob_next), 64'd2);

        // Alloc to the same rd as the retiring head
        do_reset();
        alloc = 1'b1; alloc_rd = 5'd5;
        tick();
        ntf = 1'b1; at = 4'd1; val = 32'h5;
        push_ret(5'd5, 4'd1, 32'h5);
`ifndef ROB_BYPASS_EN
        tick();
`endif
        alloc = 1'b1; alloc_rd = 5'd5; rl = 5'd5; rr = 5'd0;
        #1;
        chk("same-rd retiring rob_wait", 64'(rob_wait), 64'd0);
        tick();
        chk("same-rd new rob_wait", 64'(rob_wait), 64'b10);
        chk("same-rd new rob_rl", 64'(rob_rl), 64'd2);
        drain();

        // ntf-to-rwrite latency
        do_reset();
        alloc = 1'b1; alloc_rd = 5'd8;
        tick();
        ntf = 1'b1; at = 4'd1; val = 32'h7;
        push_ret(5'd8, 4'd1, 32'h7);
        tick();
`ifdef ROB_BYPASS_EN
        chk("latency edge1 rwrite", 64'(rwrite), 64'd8);
        tick();
        chk("latency edge2 rwrite", 64'(rwrite), 64'd0);
`else
        chk("latency edge1 rwrite", 64'(rwrite), 64'd0);
        tick();
        chk("latency edge2 rwrite", 64'(rwrite), 64'd8);
`endif
        drain();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 Parameter WIDTH, default 32, data path width.
REQ-002 Parameter SIZE, default 8, reservation-station count; ROB index width IW = clog2(SIZE)+1; DEPTH = 2*SIZE.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 alloc  in  1  allocate one entry this cycle.
REQ-006 alloc_rd  in  5  destination register of allocated instruction.
REQ-007 rl, rr  in  5 each  source registers to look up.
REQ-008 full  out  1  no entry free.
REQ-009 rob_next  out  IW  index the next alloc receives.
REQ-010 rob_wait  out  2  [1]=rl pending, [0]=rr pending.
REQ-011 rob_rl, rob_rr  out  IW each  producer index for rl / rr.
REQ-012 ntf, exc, val, at  in  1/3/WIDTH/IW  completion from issue stage.
REQ-013 rwrite  out  5  retiring destination register, R_ZERO when idle.
REQ-014 rbus  out  IW  retiring ROB index; result  out  WIDTH  retiring value.
REQ-015 flush  out  1  one-cycle pipeline flush; flush_exc  out  3; flush_at  out  IW.

Function
REQ-016 Usable indices 1..DEPTH-1, circular; index 0 never allocated; successor of DEPTH-1 is 1.
REQ-017 full SHALL be combinational: count == DEPTH-1; rob_next = tail.
REQ-018 alloc & !full SHALL write entry tail {busy=1, done=0, rd=alloc_rd}, advance tail, count+1; alloc & full ignored.
REQ-019 Rename map per register: alloc with alloc_rd != R_ZERO sets map[alloc_rd]=tail, pending=1.
REQ-020 Lookup combinational from current map (pre-alloc): rob_wait[1]=pending[rl] & rl!=R_ZERO & map[rl] not retiring this cycle; same for rr, also 0 when rr==5'h1F (immediate).
REQ-021 ntf with busy[at] SHALL set done, store val/exc at edge; ntf to non-busy entry ignored.
REQ-022 Retire: head busy & done & exc==EXC_NONE -> next edge rwrite=rd, rbus=head, result=val, free head, head+1, count-1; else rwrite=R_ZERO.
REQ-023 Retire clears pending[rd] only if map[rd]==head; simultaneous alloc to same rd wins (pending stays 1, map=new index).
REQ-024 Alloc and retire same cycle: count unchanged.
REQ-025 Head done with exc != EXC_NONE -> next edge flush=1, flush_exc=exc, flush_at=head, rwrite=R_ZERO; all entries freed, head=tail=1, count=0, all pending cleared.
REQ-026 During flush-decision cycle, alloc and ntf SHALL be dropped.
REQ-027 Outputs rwrite/rbus/result/flush/flush_exc/flush_at registered; flush high exactly one cycle.
REQ-028 Retire at most one entry per cycle, strictly in order.

Reset
REQ-029 rst low: head=tail=1, count=0, all busy/done/pending=0, rwrite=R_ZERO, rbus=0, result=0, flush=0, flush_exc=EXC_NONE, flush_at=0, immediately and asynchronously.
REQ-030 Reset mid-operation discards all entries; first alloc after release gets index 1.

Configuration
REQ-031 Macro ROB_BYPASS_EN defined: ntf with at==head and exc==EXC_NONE retires on the same edge it arrives (ntf-to-rwrite latency 1); exc!=EXC_NONE flushes on that edge.
REQ-032 ROB_BYPASS_EN undefined: ntf only marks done; retire one edge later (latency 2).

Verification
REQ-033 Reset, alloc rd=3 -> rob_next=1 before, 2 after; lookup rl=3 -> rob_wait[1]=1, rob_rl=1.
REQ-034 Alloc idx1 rd=3, idx2 rd=4; ntf at=2 val=0x22, then at=1 val=0x11 -> rwrite 3/0x11 rbus=1, next cycle 4/0x22 rbus=2.
REQ-035 15 allocs without ntf -> full=1, 16th alloc ignored; retire idx1 -> next alloc gets 1 (wrap).
REQ-036 ntf at=1 exc=EXC_BPRED with idx2..5 busy -> flush=1 one cycle, flush_at=1, rwrite=R_ZERO, count=0, rob_next=1.
REQ-037 Alloc rd=5 same cycle idx1 (rd=5) retires -> pending[5]=1, map[5]=new index; rl=5 same cycle -> rob_wait[1]=0.
REQ-038 ROB_BYPASS_EN: ntf at=head val=0x7 -> rwrite valid next cycle; undefined: two cycles.
